// File: rtl/fib_stream_checker_if.sv
// Valid/ready word stream carried from a Fibonacci source into the checker.
// The master drives valid/data, the slave answers with ready.
interface fib_stream_checker_if #(
  parameter int W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fib_stream_checker.sv
// Sink-side Fibonacci checker: regenerates F(n) mod 2^W and compares it with
// each accepted stream word, reporting pass/fail, first error and match count.
module fib_stream_checker #(
  parameter int W       = 32,
  parameter int N_TERMS = 100,
  parameter int IW      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  fib_stream_checker_if.slave   s,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  err_o,
  output logic [IW-1:0]         err_idx_o,
  output logic [W-1:0]          err_data_o,
  output logic [IW-1:0]         match_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_TERMS - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  state_t        state_q,     state_d;
  logic [W-1:0]  exp_n1_q,    exp_n1_d;
  logic [W-1:0]  exp_n2_q,    exp_n2_d;
  logic [IW-1:0] idx_q,       idx_d;
  logic [IW-1:0] match_cnt_q, match_cnt_d;
  logic          err_q,       err_d;
  logic [IW-1:0] err_idx_q,   err_idx_d;
  logic [W-1:0]  err_data_q,  err_data_d;
  logic          done_q,      done_d;
  logic          pass_q,      pass_d;

  logic          ready_s;
  logic          accept_s;
  logic [W-1:0]  exp_s;
  logic          mismatch_s;

  // The (idx==1) term seeds F(1)=1 while both history registers are still zero.
  assign exp_s      = exp_n1_q + exp_n2_q + W'(idx_q == ONE_IDX);
  assign ready_s    = (state_q == ST_RUN);
  assign accept_s   = s.valid & ready_s;
  assign mismatch_s = (s.data != exp_s);

  assign s.ready     = ready_s;
  assign busy_o      = ready_s;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_o       = err_q;
  assign err_idx_o   = err_idx_q;
  assign err_data_o  = err_data_q;
  assign match_cnt_o = match_cnt_q;

  // Next-state logic: run control, expected-value regeneration and scoring.
  always_comb begin
    state_d     = state_q;
    exp_n1_d    = exp_n1_q;
    exp_n2_d    = exp_n2_q;
    idx_d       = idx_q;
    match_cnt_d = match_cnt_q;
    err_d       = err_q;
    err_idx_d   = err_idx_q;
    err_data_d  = err_data_q;
    done_d      = done_q;
    pass_d      = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d     = ST_RUN;
          exp_n1_d    = {W{1'b0}};
          exp_n2_d    = {W{1'b0}};
          idx_d       = {IW{1'b0}};
          match_cnt_d = {IW{1'b0}};
          err_d       = 1'b0;
          err_idx_d   = {IW{1'b0}};
          err_data_d  = {W{1'b0}};
          done_d      = 1'b0;
          pass_d      = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          exp_n2_d = exp_n1_q;
          exp_n1_d = exp_s;
          idx_d    = idx_q + ONE_IDX;
          if (!mismatch_s) begin
            match_cnt_d = match_cnt_q + ONE_IDX;
          end else if (!err_q) begin
            err_d      = 1'b1;
            err_idx_d  = idx_q;
            err_data_d = s.data;
          end else begin
            err_d = err_q;
          end
          // Pass must include the verdict on the word being accepted now.
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = ~(err_q | mismatch_s);
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      exp_n1_q    <= {W{1'b0}};
      exp_n2_q    <= {W{1'b0}};
      idx_q       <= {IW{1'b0}};
      match_cnt_q <= {IW{1'b0}};
      err_q       <= 1'b0;
      err_idx_q   <= {IW{1'b0}};
      err_data_q  <= {W{1'b0}};
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_n1_q    <= exp_n1_d;
      exp_n2_q    <= exp_n2_d;
      idx_q       <= idx_d;
      match_cnt_q <= match_cnt_d;
      err_q       <= err_d;
      err_idx_q   <= err_idx_d;
      err_data_q  <= err_data_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

endmodule

// File: tb/tb_fib_stream_checker.sv
// Randomized self-checking bench for fib_stream_checker against a reference
// model built from a directly computed Fibonacci table and stream scoring.
module tb_fib_stream_checker;

  localparam int W  = 32;
  localparam int N  = 100;
  localparam int IW = 7;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy, done, pass, err;
  logic [IW-1:0] err_idx, match_cnt;
  logic [W-1:0]  err_data;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fib  [0:N-1];
  logic [W-1:0] stim [0:N-1];

  fib_stream_checker_if #(.W(W)) sif ();

  fib_stream_checker #(.W(W), .N_TERMS(N), .IW(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (sif.slave),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .err_o       (err),
    .err_idx_o   (err_idx),
    .err_data_o  (err_data),
    .match_cnt_o (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden sequence straight from the recurrence, wrapping mod 2^32.
  task automatic build_fib();
    fib[0] = 32'd0;
    fib[1] = 32'd1;
    for (int n = 2; n < N; n++) fib[n] = fib[n-1] + fib[n-2];
    for (int n = 0; n < N; n++) stim[n] = fib[n];
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || err !== 1'b0 ||
        err_idx !== 7'd0 || err_data !== 32'd0 || match_cnt !== 7'd0) begin
      errors++;
      $display("FAIL start_clear: busy=%b done=%b pass=%b err=%b idx=%0d data=%0d mc=%0d, required busy=1 rest 0",
               busy, done, pass, err, err_idx, err_data, match_cnt);
    end
  endtask

  // Feeds stim[] with random valid gaps, scoring each word against fib[].
  task automatic feed(input int duty, input bit mid_start, input bit last_start,
                      output int m, output bit e, output int ei, output logic [W-1:0] ed);
    int  i = 0;
    int  guard = 0;
    bit  v;
    m = 0; e = 1'b0; ei = 0; ed = '0;
    while (i < N && guard < 2000) begin
      v = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      sif.valid = v;
      sif.data  = stim[i];
      start     = (mid_start && i == 40) || (last_start && v && i == N - 1);
      @(negedge clk);
      if (v) begin
        if (stim[i] == fib[i]) m++;
        else if (!e) begin e = 1'b1; ei = i; ed = stim[i]; end
        i++;
      end
      guard++;
      if (i < N) begin
        checks++;
        if (busy !== 1'b1 || sif.ready !== 1'b1 || match_cnt !== 7'(m) || err !== e) begin
          errors++;
          $display("FAIL run_track[%0d]: busy=%b rdy=%b mc=%0d err=%b, required 1 1 %0d %b",
                   i, busy, sif.ready, match_cnt, err, m, e);
        end
      end
    end
    sif.valid = 1'b0;
    start     = 1'b0;
    checks++;
    if (guard >= 2000) begin
      errors++;
      $display("FAIL feed_timeout: accepted %0d words, required %0d", i, N);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sif.ready !== 1'b0 || pass !== !e ||
        err !== e || match_cnt !== 7'(m)) begin
      errors++;
      $display("FAIL run_end: done=%b busy=%b rdy=%b pass=%b err=%b mc=%0d, required 1 0 0 %b %b %0d",
               done, busy, sif.ready, pass, err, match_cnt, !e, e, m);
    end
    checks++;
    if (e && (err_idx !== 7'(ei) || err_data !== ed)) begin
      errors++;
      $display("FAIL err_capture: idx=%0d data=%0d, required %0d %0d", err_idx, err_data, ei, ed);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; sif.valid = 1'b0; sif.data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err !== 1'b0 || sif.ready !== 1'b0 ||
        err_idx !== 7'd0 || err_data !== 32'd0 || match_cnt !== 7'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b pass=%b err=%b rdy=%b mc=%0d, required all 0",
               busy, done, pass, err, sif.ready, match_cnt);
    end
    rst = 1'b1;
    sif.valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (sif.ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_accept: rdy=%b busy=%b, required 0 0", sif.ready, busy);
    end
    sif.valid = 1'b0;
  endtask

  task automatic test_clean();
    int m, ei; bit e; logic [W-1:0] ed;
    for (int n = 0; n < N; n++) stim[n] = fib[n];
    do_start();
    feed(100, 1'b0, 1'b0, m, e, ei, ed);
    checks++;
    if (pass !== 1'b1 || match_cnt !== 7'd100 || err !== 1'b0) begin
      errors++;
      $display("FAIL clean_run: pass=%b mc=%0d err=%b, required 1 100 0", pass, match_cnt, err);
    end
  endtask

  task automatic test_single_corrupt();
    int m, ei; bit e; logic [W-1:0] ed;
    for (int n = 0; n < N; n++) stim[n] = fib[n];
    stim[10] = 32'd54;
    do_start();
    feed(100, 1'b0, 1'b0, m, e, ei, ed);
    checks++;
    if (pass !== 1'b0 || err_idx !== 7'd10 || err_data !== 32'd54 || match_cnt !== 7'd99) begin
      errors++;
      $display("FAIL single_corrupt: pass=%b idx=%0d data=%0d mc=%0d, required 0 10 54 99",
               pass, err_idx, err_data, match_cnt);
    end
  endtask

  task automatic test_multi_corrupt();
    int m, ei; bit e; logic [W-1:0] ed;
    logic [W-1:0] bad3;
    for (int n = 0; n < N; n++) stim[n] = fib[n];
    bad3 = fib[3] ^ ($urandom() | 32'd1);
    stim[3]  = bad3;
    stim[20] = fib[20] + 32'd7;
    do_start();
    feed(70, 1'b0, 1'b0, m, e, ei, ed);
    checks++;
    if (err_idx !== 7'd3 || err_data !== bad3 || match_cnt !== 7'd98 || pass !== 1'b0) begin
      errors++;
      $display("FAIL multi_corrupt: idx=%0d data=%0d mc=%0d pass=%b, required 3 %0d 98 0",
               err_idx, err_data, match_cnt, pass, bad3);
    end
  endtask

  task automatic test_random_gaps();
    int m, ei; bit e; logic [W-1:0] ed;
    for (int n = 0; n < N; n++) stim[n] = fib[n];
    do_start();
    feed(50, 1'b1, 1'b1, m, e, ei, ed);
    checks++;
    if (pass !== 1'b1 || match_cnt !== 7'd100) begin
      errors++;
      $display("FAIL gap_run: pass=%b mc=%0d, required 1 100", pass, match_cnt);
    end
    // start coincided with the last transfer, and s_valid now pushes into DONE
    sif.valid = 1'b1;
    sif.data  = 32'd0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || sif.ready !== 1'b0 || match_cnt !== 7'd100) begin
        errors++;
        $display("FAIL done_hold: done=%b busy=%b rdy=%b mc=%0d, required 1 0 0 100",
                 done, busy, sif.ready, match_cnt);
      end
    end
    sif.valid = 1'b0;
  endtask

  task automatic test_random_corrupt();
    int m, ei; bit e; logic [W-1:0] ed;
    for (int n = 0; n < N; n++) stim[n] = fib[n];
    for (int k = 0; k < 4; k++) begin
      int p = $urandom_range(0, N - 1);
      stim[p] = fib[p] ^ ($urandom() | 32'h8000_0000);
    end
    do_start();
    feed(60, 1'b0, 1'b0, m, e, ei, ed);
  endtask

  task automatic test_reset_midrun();
    int m, ei; bit e; logic [W-1:0] ed;
    for (int n = 0; n < N; n++) stim[n] = fib[n];
    do_start();
    for (int k = 0; k < 40; k++) begin
      sif.valid = 1'b1;
      sif.data  = fib[k];
      @(negedge clk);
    end
    sif.valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err !== 1'b0 ||
        sif.ready !== 1'b0 || match_cnt !== 7'd0 || err_idx !== 7'd0 || err_data !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b rdy=%b mc=%0d, required all 0",
               busy, done, sif.ready, match_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    do_start();
    feed(100, 1'b0, 1'b0, m, e, ei, ed);
    checks++;
    if (pass !== 1'b1 || match_cnt !== 7'd100) begin
      errors++;
      $display("FAIL rerun_after_reset: pass=%b mc=%0d, required 1 100", pass, match_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int m, ei; bit e; logic [W-1:0] ed;
    for (int n = 0; n < N; n++) stim[n] = fib[n];
    stim[N-1] = fib[N-1] + 32'd1;
    do_start();
    feed(100, 1'b0, 1'b0, m, e, ei, ed);
    checks++;
    if (pass !== 1'b0 || err_idx !== 7'd99 || match_cnt !== 7'd99) begin
      errors++;
      $display("FAIL last_word_fail: pass=%b idx=%0d mc=%0d, required 0 99 99", pass, err_idx, match_cnt);
    end
    for (int n = 0; n < N; n++) stim[n] = fib[n];
    do_start();
    feed(100, 1'b0, 1'b0, m, e, ei, ed);
    checks++;
    if (pass !== 1'b1 || match_cnt !== 7'd100 || err !== 1'b0) begin
      errors++;
      $display("FAIL second_run: pass=%b mc=%0d err=%b, required 1 100 0", pass, match_cnt, err);
    end
  endtask

  initial begin
    build_fib();
    test_reset();
    test_clean();
    test_single_corrupt();
    test_multi_corrupt();
    test_random_gaps();
    test_random_corrupt();
    test_reset_midrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_stream_checker.md
Name: fib_stream_checker

Overview:
- Receive-side counterpart of the Fibonacci sequence generator.
- Consumes a valid/ready stream of W-bit words and checks each word against an internally regenerated sequence F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2) mod 2^W.
- Checks a run of N_TERMS words, then reports pass/fail, the first mismatching index and the match count.
- Sits at the sink end of the generator datapath in self-test benches and on-chip BIST.

Parameters:
- W, 32, data width; all sequence arithmetic is modulo 2^W.
- N_TERMS, 100, words checked per run; legal range 2..127.
- IW, 7, index/counter width; must satisfy 2^IW > N_TERMS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- s_valid  in  1  input word valid.
- s_data  in  W  input word.
- s_ready  out  1  checker accepts a word this cycle.
- busy  out  1  run in progress.
- done  out  1  run finished; holds until next start.
- pass  out  1  done and no mismatch; only meaningful while done=1.
- err  out  1  sticky; set on the first mismatch of a run.
- err_idx  out  IW  index of the first mismatching word.
- err_data  out  W  received word at the first mismatch.
- match_cnt  out  IW  number of matching words in the current or last run.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; exp_n1=0, exp_n2=0, idx=0.
- FSM states:
  - IDLE: s_ready=0. start -> RUN.
  - RUN: busy=1, s_ready=1. After the N_TERMS-th accepted word -> DONE.
  - DONE: done=1, s_ready=0. start -> RUN.
- Entering RUN (the cycle after start):
  - idx=0, match_cnt=0, err=0, err_idx=0, err_data=0, pass=0, done=0.
  - Expected-value registers cleared.
- Expected word, combinational from registered state:
  - exp = exp_n1 + exp_n2 + (idx==1), truncated to W bits.
  - Yields 0, 1, 1, 2, 3, 5, ...
- Transfer: a word is accepted when s_valid && s_ready. On each accepted word:
  - exp_n2 <= exp_n1; exp_n1 <= exp; idx <= idx+1.
  - If s_data == exp: match_cnt increments.
  - Else, if err=0: err<=1, err_idx<=idx, err_data<=s_data. Later mismatches only fail to increment match_cnt.
  - Checking continues after a mismatch; the run always consumes exactly N_TERMS words.
- No transfer (s_valid=0 in RUN): all state holds. Stalls of any length are legal.
- Last word (idx==N_TERMS-1 accepted):
  - Next cycle: DONE, done=1, busy=0, s_ready=0.
  - pass = (err==0 after including the last word's comparison).
- Latency: err and match_cnt reflect a word one cycle after its acceptance.
- Wrap-around: expected-value additions overflow modulo 2^W silently; no saturation, no flag.
- Boundary conditions:
  - start while in RUN: ignored; the run continues.
  - start in the same cycle as the last transfer: the transfer completes and the FSM goes to DONE; start is ignored.
  - s_valid in IDLE/DONE: not accepted (s_ready=0); the word is not consumed.
- Reset mid-run: asynchronously returns to IDLE with all outputs 0. The partial run is discarded.

Test Plan:
- Clean run, W=32, N_TERMS=100: start, then feed F(0..99) mod 2^32 back-to-back -> DONE 100 words after the first accept; pass=1, err=0, match_cnt=100. Exercises wrap: F(48) is expected as 512559680.
- Single corruption: feed the correct stream but word 10 = 54 instead of 55 -> err=1 one cycle after that accept, err_idx=10, err_data=54; final pass=0, match_cnt=99.
- Multiple corruptions at indices 3 and 20 -> err_idx=3 (first only), err_data=the wrong value at index 3, match_cnt=98.
- Random s_valid gaps (~50% duty) with a correct stream -> identical final result to the clean run; each stall cycle holds idx and the expected values.
- rst asserted asynchronously after 40 words, then released and start pulsed -> all outputs 0 during reset; the new run begins at F(0) and passes with match_cnt=100. start pulsed mid-run and s_valid held in DONE -> no effect, s_ready=0.
- Back-to-back runs: start in DONE after a failed run -> err, err_idx, err_data, match_cnt and pass cleared the cycle after start; the second, clean run passes.
